// File: rtl/lisa_pc_sequencer_pkg.sv
// Shared widths, limits and state encoding for the PC sequencer.
package lisa_pc_sequencer_pkg;

  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned LEN_W             = 8;
  localparam int unsigned TAG_W             = 8;
  localparam int unsigned LISA_MAX_INST_LEN = 16;

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_FETCH    = 3'd1,
    SEQ_WAIT_RSP = 3'd2,
    SEQ_ISSUE    = 3'd3,
    SEQ_EXEC     = 3'd4,
    SEQ_HALT     = 3'd5,
    SEQ_FAULT    = 3'd6
  } seq_state_e;

  // A fetched length is illegal when zero or longer than the largest instruction.
  function automatic logic len_illegal(input logic [LEN_W-1:0] len,
                                       input int unsigned max_len);
    return (len == '0) || (32'(len) > max_len);
  endfunction

endpackage

// File: rtl/lisa_pc_sequencer_if.sv
// Fetch, issue and control-flow handshake bundle between sequencer and its neighbours.
interface lisa_pc_sequencer_if;
  import lisa_pc_sequencer_pkg::*;

  logic              fetch_req_valid;
  logic              fetch_req_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_rsp_valid;
  logic [LEN_W-1:0]  fetch_rsp_len;
  logic              fetch_rsp_err;
  logic              inst_valid;
  logic              inst_ready;
  logic [ADDR_W-1:0] inst_pc;
  logic [LEN_W-1:0]  inst_len;
  logic              exec_done;
  logic [ADDR_W-1:0] cf_next_pc;
  logic              cf_pred_tag_we;
  logic [TAG_W-1:0]  cf_pred_tag_next;
  logic              cf_halt;

  modport master (
    output fetch_req_valid, fetch_addr, inst_valid, inst_pc, inst_len,
    input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_len, fetch_rsp_err,
    input  inst_ready, exec_done, cf_next_pc, cf_pred_tag_we, cf_pred_tag_next, cf_halt
  );

  modport slave (
    input  fetch_req_valid, fetch_addr, inst_valid, inst_pc, inst_len,
    output fetch_req_ready, fetch_rsp_valid, fetch_rsp_len, fetch_rsp_err,
    output inst_ready, exec_done, cf_next_pc, cf_pred_tag_we, cf_pred_tag_next, cf_halt
  );

endinterface

// File: rtl/lisa_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module lisa_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear, hold at all-ones, or step by one.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/lisa_pc_sequencer.sv
// Run/halt controller owning pc, pred_tag and halt state; sequences fetch -> issue -> exec.
module lisa_pc_sequencer
  import lisa_pc_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned MAX_INST_LEN = LISA_MAX_INST_LEN,
  parameter int unsigned RETIRE_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   entry_pc,
  lisa_pc_sequencer_if.master bus,
  output logic [ADDR_W-1:0]   pc,
  output logic [TAG_W-1:0]    pred_tag,
  output logic                busy,
  output logic                halted,
  output logic                fault,
  output logic [RETIRE_W-1:0] retired_count
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [TAG_W-1:0]  pred_tag_q, pred_tag_d;
  logic [LEN_W-1:0]  inst_len_q, inst_len_d;
  logic              fetch_req_valid_q, fetch_req_valid_d;
  logic              inst_valid_q, inst_valid_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  logic              cnt_clr, cnt_inc;

  // Next state, architectural updates and registered-output decode of the next state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pred_tag_d = pred_tag_q;
    inst_len_d = inst_len_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;

    unique case (state_q)
      SEQ_IDLE, SEQ_HALT, SEQ_FAULT: begin
        if (start) begin
          pc_d       = entry_pc;
          pred_tag_d = '0;
          cnt_clr    = 1'b1;
          state_d    = SEQ_FETCH;
        end
      end
      SEQ_FETCH: begin
        if (bus.fetch_req_ready) begin
          state_d = SEQ_WAIT_RSP;
        end
      end
      SEQ_WAIT_RSP: begin
        if (bus.fetch_rsp_valid) begin
          if (bus.fetch_rsp_err || len_illegal(bus.fetch_rsp_len, MAX_INST_LEN)) begin
            state_d = SEQ_FAULT;
          end else begin
            inst_len_d = bus.fetch_rsp_len;
            state_d    = SEQ_ISSUE;
          end
        end
      end
      SEQ_ISSUE: begin
        if (bus.inst_ready) begin
          state_d = SEQ_EXEC;
        end
      end
      SEQ_EXEC: begin
        if (bus.exec_done) begin
          pc_d    = bus.cf_next_pc;
          cnt_inc = 1'b1;
          if (bus.cf_pred_tag_we) begin
            pred_tag_d = bus.cf_pred_tag_next;
          end
          state_d = bus.cf_halt ? SEQ_HALT : SEQ_FETCH;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    fetch_req_valid_d = (state_d == SEQ_FETCH);
    inst_valid_d      = (state_d == SEQ_ISSUE);
    halted_d          = (state_d == SEQ_HALT);
    fault_d           = (state_d == SEQ_FAULT);
    busy_d            = !(state_d inside {SEQ_IDLE, SEQ_HALT, SEQ_FAULT});
  end

  // State and output registers; reset abandons any in-flight handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= SEQ_IDLE;
      pc_q              <= RESET_PC;
      pred_tag_q        <= '0;
      inst_len_q        <= '0;
      fetch_req_valid_q <= 1'b0;
      inst_valid_q      <= 1'b0;
      busy_q            <= 1'b0;
      halted_q          <= 1'b0;
      fault_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      pred_tag_q        <= pred_tag_d;
      inst_len_q        <= inst_len_d;
      fetch_req_valid_q <= fetch_req_valid_d;
      inst_valid_q      <= inst_valid_d;
      busy_q            <= busy_d;
      halted_q          <= halted_d;
      fault_q           <= fault_d;
    end
  end

  // Retired-instruction counter.
  lisa_sat_counter #(.WIDTH(RETIRE_W)) u_retire_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (retired_count)
  );

  assign bus.fetch_req_valid = fetch_req_valid_q;
  assign bus.fetch_addr      = pc_q;
  assign bus.inst_valid      = inst_valid_q;
  assign bus.inst_pc         = pc_q;
  assign bus.inst_len        = inst_len_q;
  assign pc                  = pc_q;
  assign pred_tag            = pred_tag_q;
  assign busy                = busy_q;
  assign halted              = halted_q;
  assign fault               = fault_q;

endmodule

// File: tb/tb_lisa_pc_sequencer.sv
// Scoreboard bench: driver pushes expectations from a program-level model, monitor compares on handshakes.
module tb_lisa_pc_sequencer;

  localparam logic [15:0] RST_PC  = 16'h0ABC;
  localparam int unsigned RW      = 4;
  localparam int unsigned CNT_MAX = (1 << RW) - 1;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  tag;
    logic [31:0] cnt;
    logic        halt;
  } ret_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   entry_pc = '0;
  logic [15:0]   pc;
  logic [7:0]    pred_tag;
  logic          busy, halted, fault;
  logic [RW-1:0] retired_count;

  lisa_pc_sequencer_if bif();

  lisa_pc_sequencer #(.RESET_PC(RST_PC), .MAX_INST_LEN(16), .RETIRE_W(RW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .entry_pc      (entry_pc),
    .bus           (bif.master),
    .pc            (pc),
    .pred_tag      (pred_tag),
    .busy          (busy),
    .halted        (halted),
    .fault         (fault),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  // Program-level reference state.
  logic [15:0] m_pc;
  logic [7:0]  m_tag;
  int unsigned m_cnt;

  logic [15:0] fetch_q[$];
  logic [23:0] issue_q[$];
  ret_t        ret_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: stability under backpressure, handshake payloads, post-retirement state.
  logic        prev_fv = 1'b0, prev_iv = 1'b0;
  logic [15:0] prev_fa = '0;
  logic [23:0] prev_inst = '0;
  bit          ret_pend = 1'b0;
  int unsigned last_fhs = 0, fetch_gap = 0;
  ret_t        r;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_fv  = 1'b0;
      prev_iv  = 1'b0;
      ret_pend = 1'b0;
    end else begin
      if (prev_fv) begin
        chk("fetch_valid_held", 32'(bif.fetch_req_valid), 32'd1);
        chk("fetch_addr_held", 32'(bif.fetch_addr), 32'(prev_fa));
      end
      if (prev_iv) begin
        chk("inst_valid_held", 32'(bif.inst_valid), 32'd1);
        chk("inst_payload_held", 32'({bif.inst_pc, bif.inst_len}), 32'(prev_inst));
      end
      prev_fv   = bif.fetch_req_valid && !bif.fetch_req_ready;
      prev_fa   = bif.fetch_addr;
      prev_iv   = bif.inst_valid && !bif.inst_ready;
      prev_inst = {bif.inst_pc, bif.inst_len};

      if (bif.fetch_req_valid && bif.fetch_req_ready) begin
        if (fetch_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL fetch_unexpected actual=%0h expected=none", bif.fetch_addr);
        end else begin
          chk("fetch_addr", 32'(bif.fetch_addr), 32'(fetch_q.pop_front()));
        end
        fetch_gap = cyc - last_fhs;
        last_fhs  = cyc;
      end

      if (bif.inst_valid && bif.inst_ready) begin
        if (issue_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL issue_unexpected actual=%0h expected=none", {bif.inst_pc, bif.inst_len});
        end else begin
          chk("issue_pc_len", 32'({bif.inst_pc, bif.inst_len}), 32'(issue_q.pop_front()));
        end
      end

      if (ret_pend) begin
        r = ret_q.pop_front();
        chk("ret_pc", 32'(pc), 32'(r.pc));
        chk("ret_pred_tag", 32'(pred_tag), 32'(r.tag));
        chk("ret_count", 32'(retired_count), r.cnt);
        chk("ret_halted", 32'(halted), 32'(r.halt));
        chk("ret_busy", 32'(busy), 32'(!r.halt));
        ret_pend = 1'b0;
      end
      if (bif.exec_done && ret_q.size() > 0) ret_pend = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] entry);
    entry_pc = entry;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    m_pc  = entry;
    m_tag = '0;
    m_cnt = 0;
  endtask

  task automatic do_fetch(input int rw, input bit spur);
    int n = 0;
    while (!bif.fetch_req_valid && n < 20) begin tick(); n++; end
    chk("fetch_wait", 32'(bif.fetch_req_valid), 32'd1);
    if (spur) begin
      bif.exec_done       = 1'b1;
      bif.cf_next_pc      = 16'hBEEF;
      bif.cf_halt         = 1'b1;
      bif.fetch_rsp_valid = 1'b1;
      bif.fetch_rsp_err   = 1'b1;
      tick();
      bif.exec_done       = 1'b0;
      bif.cf_halt         = 1'b0;
      bif.fetch_rsp_valid = 1'b0;
      bif.fetch_rsp_err   = 1'b0;
      chk("spur_fetch_still", 32'(bif.fetch_req_valid), 32'd1);
      chk("spur_fetch_pc", 32'(pc), 32'(m_pc));
      chk("spur_fetch_count", 32'(retired_count), 32'(m_cnt));
      chk("spur_fetch_nofault", 32'(fault), 32'd0);
    end
    repeat (rw) tick();
    bif.fetch_req_ready = 1'b1;
    tick();
    bif.fetch_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [7:0] len, input logic err);
    bif.fetch_rsp_valid = 1'b1;
    bif.fetch_rsp_len   = len;
    bif.fetch_rsp_err   = err;
    tick();
    bif.fetch_rsp_valid = 1'b0;
    bif.fetch_rsp_err   = 1'b0;
    bif.fetch_rsp_len   = 8'hEE;
  endtask

  task automatic do_issue(input int iw);
    int n = 0;
    while (!bif.inst_valid && n < 20) begin tick(); n++; end
    chk("issue_wait", 32'(bif.inst_valid), 32'd1);
    repeat (iw) tick();
    bif.inst_ready = 1'b1;
    tick();
    bif.inst_ready = 1'b0;
  endtask

  // One full instruction: fetch, respond, issue, execute with the given control-flow result.
  task automatic step(input logic [15:0] npc, input logic we, input logic [7:0] ntag,
                      input logic halt, input logic [7:0] len,
                      input int rw, input int iw, input int ew, input bit spur);
    fetch_q.push_back(m_pc);
    issue_q.push_back({m_pc, len});
    do_fetch(rw, spur);
    respond(len, 1'b0);
    do_issue(iw);
    if (spur) begin
      entry_pc = 16'hDEAD;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      chk("spur_start_pc", 32'(pc), 32'(m_pc));
      chk("spur_start_busy", 32'(busy), 32'd1);
      chk("spur_start_nofetch", 32'(bif.fetch_req_valid), 32'd0);
      chk("spur_start_count", 32'(retired_count), 32'(m_cnt));
    end
    repeat (ew) tick();
    m_pc = npc;
    if (we) m_tag = ntag;
    if (m_cnt < CNT_MAX) m_cnt++;
    ret_q.push_back('{pc: m_pc, tag: m_tag, cnt: 32'(m_cnt), halt: halt});
    bif.exec_done        = 1'b1;
    bif.cf_next_pc       = npc;
    bif.cf_pred_tag_we   = we;
    bif.cf_pred_tag_next = ntag;
    bif.cf_halt          = halt;
    tick();
    bif.exec_done      = 1'b0;
    bif.cf_pred_tag_we = 1'b0;
    bif.cf_halt        = 1'b0;
  endtask

  task automatic fault_fetch(input logic [7:0] len, input logic err);
    fetch_q.push_back(m_pc);
    do_fetch(0, 1'b0);
    respond(len, err);
    chk("fault_flag", 32'(fault), 32'd1);
    chk("fault_pc", 32'(pc), 32'(m_pc));
    chk("fault_busy", 32'(busy), 32'd0);
    chk("fault_no_issue", 32'(bif.inst_valid), 32'd0);
    chk("fault_count", 32'(retired_count), 32'(m_cnt));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"}, 32'(pc), 32'(RST_PC));
    chk({tag, "_tag"}, 32'(pred_tag), 32'd0);
    chk({tag, "_count"}, 32'(retired_count), 32'd0);
    chk({tag, "_status"}, 32'({busy, halted, fault}), 32'd0);
    chk({tag, "_valids"}, 32'({bif.fetch_req_valid, bif.inst_valid}), 32'd0);
    chk({tag, "_inst_len"}, 32'(bif.inst_len), 32'd0);
  endtask

  initial begin
    bif.fetch_req_ready  = 1'b0;
    bif.fetch_rsp_valid  = 1'b0;
    bif.fetch_rsp_len    = '0;
    bif.fetch_rsp_err    = 1'b0;
    bif.inst_ready       = 1'b0;
    bif.exec_done        = 1'b0;
    bif.cf_next_pc       = '0;
    bif.cf_pred_tag_we   = 1'b0;
    bif.cf_pred_tag_next = '0;
    bif.cf_halt          = 1'b0;
    m_pc = RST_PC; m_tag = '0; m_cnt = 0;

    repeat (2) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Straight-line run then halt; zero-wait steps give a 4-cycle fetch cadence.
    do_start(16'h0100);
    step(16'h0104, 1'b0, 8'h00, 1'b0, 8'd4, 0, 0, 0, 1'b0);
    step(16'h0108, 1'b0, 8'h00, 1'b1, 8'd4, 0, 0, 0, 1'b0);
    chk("throughput_gap", 32'(fetch_gap), 32'd4);
    tick();
    chk("halt_state", 32'({halted, busy, fault}), 32'b100);
    chk("halt_count", 32'(retired_count), 32'd2);
    chk("halt_pc", 32'(pc), 32'h0108);
    chk("halt_no_fetch", 32'(bif.fetch_req_valid), 32'd0);

    // Branch with tag write, then a step that leaves the tag alone, then backpressure.
    do_start(16'h0300);
    chk("start_clears_count", 32'(retired_count), 32'd0);
    step(16'h0200, 1'b1, 8'h07, 1'b0, 8'd3, 0, 0, 0, 1'b0);
    step(16'h0210, 1'b0, 8'h55, 1'b0, 8'd6, 0, 0, 1, 1'b0);
    chk("tag_kept", 32'(pred_tag), 32'h07);
    step(16'h0220, 1'b1, 8'h99, 1'b1, 8'd9, 3, 2, 2, 1'b0);

    // Faults: bus error, zero length, over-long length; start recovers.
    do_start(16'h0010);
    fault_fetch(8'd4, 1'b1);
    do_start(16'h0020);
    fault_fetch(8'd0, 1'b0);
    do_start(16'h0030);
    fault_fetch(8'd17, 1'b0);
    do_start(16'h0040);
    chk("recover_count", 32'(retired_count), 32'd0);
    chk("recover_status", 32'({busy, fault}), 32'b10);
    step(16'h0050, 1'b0, 8'h00, 1'b0, 8'd16, 0, 1, 0, 1'b0);

    // Spurious start in EXEC, spurious exec_done and response in FETCH.
    step(16'h0060, 1'b1, 8'h3C, 1'b0, 8'd2, 1, 0, 0, 1'b1);

    // Random run long enough to saturate the retired counter.
    for (int i = 0; i < 18; i++) begin
      step(16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), (i == 17),
           8'($urandom_range(1, 16)), $urandom_range(0, 2), $urandom_range(0, 2),
           $urandom_range(0, 2), 1'b0);
    end
    tick();
    chk("saturated", 32'(retired_count), 32'(CNT_MAX));

    // Asynchronous reset while an instruction is being offered to execute.
    do_start(16'h0500);
    fetch_q.push_back(m_pc);
    do_fetch(0, 1'b0);
    respond(8'd5, 1'b0);
    chk("pre_reset_issue", 32'(bif.inst_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    tick();
    rst_n = 1'b1;
    m_pc = RST_PC; m_tag = '0; m_cnt = 0;
    repeat (2) tick();
    chk("post_rst_idle", 32'({busy, bif.fetch_req_valid, bif.inst_valid}), 32'd0);

    chk("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    chk("issue_q_drained", 32'(issue_q.size()), 32'd0);
    chk("ret_q_drained", 32'(ret_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
